// File: rtl/mult_pkg.sv
// Shared constants for the multiplier peripheral: default operand width and
// the control-state encoding used by the shift-add multiplier.
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } mult_state_e;

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Operand/result bus between the operand registers, the multiplier and the
// SPI readback path.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = mult_pkg::MULT_WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, output a, output b,
                  input busy, input done, input product);
  modport slave  (input start, input a, input b,
                  output busy, output done, output product);
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// registered product and a one-cycle done strobe.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_shift_add_mult_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mult_state_e     state_r, state_s;
  logic [PW-1:0]   acc_r, acc_s;
  logic [PW-1:0]   mcand_r, mcand_s;
  logic [WIDTH-1:0] mplier_r, mplier_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [PW-1:0]   product_r, product_s;
  logic [PW-1:0]   sum_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;

  // Next-state, datapath and Moore output decode (outputs follow next state so they can be registered)
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    mcand_s   = mcand_r;
    mplier_s  = mplier_r;
    cnt_s     = cnt_r;
    product_s = product_r;
    sum_s     = acc_r + (mplier_r[0] ? mcand_r : {PW{1'b0}});

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_s  = {{WIDTH{1'b0}}, bus.a};
          mplier_s = bus.b;
          acc_s    = {PW{1'b0}};
          cnt_s    = {CW{1'b0}};
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_s    = sum_s;
        mcand_s  = mcand_r << 1'b1;
        mplier_s = mplier_r >> 1'b1;
        cnt_s    = cnt_r + CW'(1);
        if (cnt_r == CNT_LAST) begin
          product_s = sum_s;
          state_s   = ST_DONE;
        end else begin
          state_s   = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        // Unused encoding falls back to IDLE without touching the datapath
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s == ST_RUN) || (state_s == ST_DONE);
    done_s = (state_s == ST_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      acc_r     <= {PW{1'b0}};
      mcand_r   <= {PW{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      product_r <= {PW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      mcand_r   <= mcand_s;
      mplier_r  <= mplier_s;
      cnt_r     <= cnt_s;
      product_r <= product_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed self-checking bench for seq_shift_add_mult at WIDTH=8 and WIDTH=4.
module tb_seq_shift_add_mult;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_shift_add_mult_if #(.WIDTH(8)) if8 ();
  seq_shift_add_mult_if #(.WIDTH(4)) if4 ();

  seq_shift_add_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  seq_shift_add_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation: latency, single strobe, result, and result hold mid-op
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [15:0] exp, input logic [15:0] prev, input string tag);
    int done_at;
    int pulses;
    if8.a = av;
    if8.b = bv;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    chk({tag, "_busy_rise"}, {63'd0, if8.busy}, 64'd1);
    done_at = -1;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4) chk({tag, "_hold_prev"}, {48'd0, if8.product}, {48'd0, prev});
      if (if8.done) begin
        pulses++;
        if (done_at < 0) done_at = i;
      end
    end
    chk({tag, "_latency"}, 64'(done_at), 64'd8);
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_product"}, {48'd0, if8.product}, {48'd0, exp});
    chk({tag, "_busy_end"}, {63'd0, if8.busy}, 64'd0);
  endtask

  initial begin
    int done_at;
    int last_done;
    int pulses;
    int busy_low;
    int prod_bad;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    if8.start = 1'b0; if8.a = 8'd0; if8.b = 8'd0;
    if4.start = 1'b0; if4.a = 4'd0; if4.b = 4'd0;
    #12;
    chk("rst_busy", {63'd0, if8.busy}, 64'd0);
    chk("rst_done", {63'd0, if8.done}, 64'd0);
    chk("rst_product", {48'd0, if8.product}, 64'd0);
    chk("rst_product_w4", {56'd0, if4.product}, 64'd0);
    rst_n = 1'b1;
    tick();

    op8(8'd13, 8'd11, 16'd143, 16'd0, "m13x11");
    op8(8'd255, 8'd255, 16'd65025, 16'd143, "m255x255");
    op8(8'd0, 8'd200, 16'd0, 16'd65025, "m0x200");

    // start re-pulsed with new operands while running must not disturb the result
    if8.a = 8'd13; if8.b = 8'd11; if8.start = 1'b1;
    tick();
    if8.a = 8'd3; if8.b = 8'd3;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) if8.start = 1'b0;
      tick();
      if (if8.done) pulses++;
    end
    chk("busy_start_pulses", 64'(pulses), 64'd1);
    chk("busy_start_product", {48'd0, if8.product}, 64'd143);
    op8(8'd3, 8'd3, 16'd9, 16'd143, "m3x3");

    // start held high: back-to-back operations every WIDTH+2 cycles
    if8.a = 8'd2; if8.b = 8'd5; if8.start = 1'b1;
    done_at = -1; last_done = -1; pulses = 0; busy_low = 0; prod_bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i > 0 && !if8.busy) busy_low++;
      if (if8.done) begin
        pulses++;
        if (done_at < 0) done_at = i;
        last_done = i;
        if (if8.product != 16'd10) prod_bad++;
      end
    end
    if8.start = 1'b0;
    chk("held_pulses", 64'(pulses), 64'd3);
    chk("held_first_done", 64'(done_at), 64'd8);
    chk("held_last_done", 64'(last_done), 64'd28);
    chk("held_busy_low", 64'(busy_low), 64'd3);
    chk("held_bad_products", 64'(prod_bad), 64'd0);
    chk("held_product", {48'd0, if8.product}, 64'd10);
    tick();

    // asynchronous reset in the middle of 7*6
    op8(8'd13, 8'd11, 16'd143, 16'd10, "m13x11_again");
    if8.a = 8'd7; if8.b = 8'd6; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick(); tick(); tick();
    chk("pre_abort_product", {48'd0, if8.product}, 64'd143);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_product", {48'd0, if8.product}, 64'd0);
    chk("abort_busy", {63'd0, if8.busy}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (if8.done) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    op8(8'd7, 8'd6, 16'd42, 16'd0, "m7x6");

    // WIDTH=4 instance
    if4.a = 4'd15; if4.b = 4'd15; if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    done_at = -1; pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (if4.done) begin
        pulses++;
        if (done_at < 0) done_at = i;
      end
    end
    chk("w4_latency", 64'(done_at), 64'd4);
    chk("w4_pulses", 64'(pulses), 64'd1);
    chk("w4_product", {56'd0, if4.product}, 64'd225);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
Sequential shift-add unsigned multiplier for the multiplier peripheral. It sits directly downstream of the operand registers, which the SPI front end loads through enable flip-flops.
- Samples both operands on a start pulse.
- Iterates one multiplier bit per clock.
- Presents a registered product with a one-cycle done strobe. The SPI readback path consumes that strobe.

Parameters:
WIDTH, 8, operand width in bits (unsigned); product is 2*WIDTH bits; legal range 2..32

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request: sample a/b and begin, honoured only in IDLE
a  input  WIDTH  multiplicand, from operand register
b  input  WIDTH  multiplier, from operand register
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle strobe, product valid
product  output  2*WIDTH  result register, holds last completed result

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without a clock edge):
  - state=IDLE.
  - busy=0, done=0, product=0.
  - Internal accumulator, shifted multiplicand, shifted multiplier and counter all cleared.
- States (Moore outputs): IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1:
    - mcand <= zero-extended a (2*WIDTH bits).
    - mplier <= b.
    - acc <= 0, cnt <= 0.
    - Go to RUN.
  - With start=0, stay in IDLE and change nothing.
- RUN, each edge:
  - acc <= acc + (mplier[0] ? mcand : 0), modulo 2^(2*WIDTH); the sum never overflows for unsigned operands.
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - cnt <= cnt + 1.
  - When cnt == WIDTH-1 on this edge:
    - product <= acc + (mplier[0] ? mcand : 0), the final sum.
    - Go to DONE.
- DONE:
  - busy=1, done=1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally.
- Latency:
  - start sampled at edge E0.
  - RUN occupies cycles E0..E0+WIDTH; product updates at edge E0+WIDTH.
  - done is high for the cycle between edges E0+WIDTH and E0+WIDTH+1.
  - IDLE again at E0+WIDTH+1.
  - Total WIDTH+2 cycles from start edge to next accepting edge.
- Operand capture:
  - a/b are sampled only at the accepting edge.
  - Changes to a/b during RUN or DONE do not affect the result.
- start while busy (RUN or DONE): ignored, not queued. The requester must re-assert start in IDLE.
- start held high continuously: a new operation begins at each IDLE edge, one operation every WIDTH+2 cycles.
- product:
  - Changes only at the final RUN edge or at reset.
  - Stable otherwise, including during a following operation until that operation completes.
- Reset asserted mid-operation: aborts immediately; no done pulse; product=0.
- Zero operands: still take the full WIDTH iterations; no early termination.
- Counter width: $clog2(WIDTH)+1 bits. No X propagation from unused states; an illegal state encoding recovers to IDLE on the next edge.

Decomposition:
- Shared package mult_pkg:
  - State encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default WIDTH constant, shared with the operand registers and the SPI readback logic.
- No sub-module required. The control FSM and the datapath (acc/mcand/mplier shifters, adder) live in one module; the datapath is small enough that splitting adds only wiring.

Test Plan:
- WIDTH=8, a=13, b=11, start 1 cycle:
  - busy rises next cycle.
  - done high exactly 9 cycles after the start edge (edge E0+8 to E0+9).
  - product=143.
- WIDTH=8, a=255, b=255: product=65025; a=0, b=200: product=0, with the same latency (no early finish).
- start re-pulsed and a/b changed to 3/3 during RUN of 13*11:
  - Result still 143, exactly one done pulse.
  - Then in IDLE, start with 3/3 gives product=9.
- start held high for 30 cycles with a=2, b=5: done pulses every 10 cycles, product=10 each time, busy low for one cycle between operations.
- Reset mid-RUN (cycle 4 of 7*6 after a prior result of 143):
  - product=0 and busy=0 immediately without a clock.
  - No done pulse.
  - Next start with 7*6 gives 42.
- WIDTH=4: a=15, b=15 gives product=225, done 5 cycles after the start edge.
